// File: rtl/mac_pkg.sv
// Shared definitions for the mac_tile_mm slice: instruction bit positions and psum fitting.
// MAC_TILE_SATURATE_EN selects clamping instead of two's-complement wrap.
package mac_pkg;

  localparam int INST_W    = 4;
  localparam int INST_SIMD = 3;
  localparam int INST_OS   = 2;
  localparam int INST_EXEC = 1;
  localparam int INST_LDFL = 0;

  // Fits a wide signed sum into pw bits, returned sign-extended to 64 bits.
  function automatic logic signed [63:0] fit_psum(input logic signed [63:0] x,
                                                  input int unsigned pw);
`ifdef MAC_TILE_SATURATE_EN
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (pw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
`else
    return (x <<< (64 - pw)) >>> (64 - pw);
`endif
  endfunction

endpackage

// File: rtl/mac_tile_mm_dot.sv
// Combinational SIMD dot product: per-lane unsigned activation times signed weight,
// summed with a signed psum addend at psum_bw+bw+2 bits.
module mac_dot #(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int lanes   = 2
) (
  input  logic        [lanes*bw-1:0]   a_i,
  input  logic        [lanes*bw-1:0]   w_i,
  input  logic signed [psum_bw-1:0]    addend_i,
  output logic signed [psum_bw+bw+1:0] sum_o
);

  localparam int WW = psum_bw + bw + 2;

  logic signed [2*bw:0] prod [lanes];

  for (genvar g = 0; g < lanes; g++) begin : g_lane
    assign prod[g] = $signed({1'b0, a_i[g*bw +: bw]}) * $signed(w_i[g*bw +: bw]);
  end

  always_comb begin
    sum_o = WW'(addend_i);
    for (int i = 0; i < lanes; i++) begin
      sum_o = sum_o + WW'(prod[i]);
    end
  end

endmodule

// File: rtl/mac_tile_mm.sv
// Multi-mode (weight-/output-stationary) SIMD MAC tile for the systolic array.
// Define MAC_TILE_SATURATE_EN to clamp psum/acc updates instead of wrapping.
module mac_tile_mm
  import mac_pkg::*;
#(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int lanes   = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [bw-1:0]       in_w,
  input  logic [psum_bw-1:0]  in_n,
  input  logic [INST_W-1:0]   inst_w,
  output logic [bw-1:0]       out_e,
  output logic [INST_W-1:0]   inst_e,
  output logic [psum_bw-1:0]  out_s,
  output logic                wt_full
);

  localparam int SW = bw / lanes;
  localparam int CW = (lanes > 1) ? $clog2(lanes) : 1;
  localparam int WW = psum_bw + bw + 2;

  logic        [bw-1:0]             out_e_q, out_e_d;
  logic        [INST_W-1:0]         inst_e_q, inst_e_d;
  logic signed [psum_bw-1:0]        out_s_q, out_s_d;
  logic signed [psum_bw-1:0]        acc_q, acc_d;
  logic        [lanes-1:0][bw-1:0]  b_q, b_d;
  logic        [CW-1:0]             cnt_q, cnt_d;
  logic                             full_q, full_d;
  logic                             simd_q, simd_d;

  logic        [lanes*bw-1:0]       dot_a, dot_w;
  logic signed [psum_bw-1:0]        dot_add;
  logic signed [WW-1:0]             dot_sum;
  logic signed [psum_bw-1:0]        dot_fit;
  logic        [CW-1:0]             cur;
  logic                             restart;

  // OS reuses lane 0 of the dot unit with acc as the addend.
  always_comb begin
    dot_a   = '0;
    dot_w   = '0;
    dot_add = $signed(in_n);
    if (inst_w[INST_OS]) begin
      dot_a[bw-1:0] = in_w;
      dot_w[bw-1:0] = in_n[bw-1:0];
      dot_add       = acc_q;
    end else if (inst_w[INST_SIMD]) begin
      dot_w = b_q;
      for (int i = 0; i < lanes; i++) begin
        dot_a[i*bw +: bw] = bw'(in_w[i*SW +: SW]);
      end
    end else begin
      dot_a[bw-1:0] = in_w;
      dot_w[bw-1:0] = b_q[0];
    end
  end

  mac_dot #(.bw(bw), .psum_bw(psum_bw), .lanes(lanes)) u_dot (
    .a_i      (dot_a),
    .w_i      (dot_w),
    .addend_i (dot_add),
    .sum_o    (dot_sum)
  );

  assign dot_fit = psum_bw'(fit_psum(64'(dot_sum), psum_bw));

  always_comb begin
    out_e_d  = out_e_q;
    inst_e_d = inst_e_q;
    out_s_d  = out_s_q;
    acc_d    = acc_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    full_d   = full_q;
    simd_d   = simd_q;
    restart  = 1'b0;
    cur      = cnt_q;
    if (inst_w[INST_EXEC]) begin
      out_e_d  = in_w;
      inst_e_d = inst_w;
      if (inst_w[INST_OS]) begin
        acc_d   = dot_fit;
        out_s_d = $signed(in_n);
      end else begin
        out_s_d = dot_fit;
      end
    end else if (inst_w[INST_LDFL]) begin
      if (inst_w[INST_OS]) begin
        out_s_d  = acc_q;
        acc_d    = $signed(in_n);
        out_e_d  = in_w;
        inst_e_d = inst_w;
      end else if (full_q) begin
        out_e_d  = in_w;
        inst_e_d = inst_w;
      end else begin
        // Filling load is absorbed; a simd-bit change mid-fill restarts the fill.
        inst_e_d = '0;
        restart  = (cnt_q != '0) && (inst_w[INST_SIMD] != simd_q);
        cur      = restart ? '0 : cnt_q;
        if (cur == '0) simd_d = inst_w[INST_SIMD];
        if (!inst_w[INST_SIMD]) begin
          for (int i = 0; i < lanes; i++) b_d[i] = in_w;
          full_d = 1'b1;
          cnt_d  = '0;
        end else begin
          b_d[cur] = in_w;
          if (cur == CW'(lanes - 1)) begin
            full_d = 1'b1;
            cnt_d  = '0;
          end else begin
            cnt_d = cur + CW'(1);
          end
        end
      end
    end else begin
      out_e_d  = in_w;
      inst_e_d = inst_w;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_e_q  <= '0;
      inst_e_q <= '0;
      out_s_q  <= '0;
      acc_q    <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      simd_q   <= 1'b0;
    end else begin
      out_e_q  <= out_e_d;
      inst_e_q <= inst_e_d;
      out_s_q  <= out_s_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      simd_q   <= simd_d;
    end
  end

  assign out_e   = out_e_q;
  assign inst_e  = inst_e_q;
  assign out_s   = out_s_q;
  assign wt_full = full_q;

endmodule

// File: tb/tb_mac_tile_mm.sv
// Self-checking bench for mac_tile_mm (bw=4, psum_bw=16, lanes=2): directed scenarios
// plus randomized WS/OS traffic against an integer reference model.
module tb_mac_tile_mm;

  localparam int BW    = 4;
  localparam int PB    = 16;
  localparam int LANES = 2;
  localparam int SWB   = BW / LANES;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [BW-1:0] in_w = '0;
  logic [PB-1:0] in_n = '0;
  logic [3:0]    inst_w = '0;
  logic [BW-1:0] out_e;
  logic [3:0]    inst_e;
  logic [PB-1:0] out_s;
  logic          wt_full;

  int checks = 0;
  int errors = 0;

  int m_b [LANES];
  int m_cnt, m_full, m_simd, m_acc, m_out_s, m_out_e, m_inst_e;

  mac_tile_mm #(.bw(BW), .psum_bw(PB), .lanes(LANES)) dut (
    .clk     (clk),
    .reset   (reset),
    .in_w    (in_w),
    .in_n    (in_n),
    .inst_w  (inst_w),
    .out_e   (out_e),
    .inst_e  (inst_e),
    .out_s   (out_s),
    .wt_full (wt_full)
  );

  always #5 clk = ~clk;

  function automatic int sx4(input int v);
    return ((v & 15) >= 8) ? (v & 15) - 16 : (v & 15);
  endfunction

  function automatic int sx16(input int v);
    return int'(shortint'(v));
  endfunction

  function automatic int fitp(input longint x);
`ifdef MAC_TILE_SATURATE_EN
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return int'(x);
`else
    return int'(shortint'(x));
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < LANES; i++) m_b[i] = 0;
    m_cnt = 0; m_full = 0; m_simd = 0; m_acc = 0;
    m_out_s = 0; m_out_e = 0; m_inst_e = 0;
  endtask

  task automatic model_step(input int inst, input int w, input int n);
    longint s;
    int ld, ex, os, simd;
    ld = inst & 1; ex = (inst >> 1) & 1; os = (inst >> 2) & 1; simd = (inst >> 3) & 1;
    if (ex == 1) begin
      if (os == 1) begin
        m_acc   = fitp(longint'(m_acc) + w * sx4(n));
        m_out_s = sx16(n);
      end else begin
        s = sx16(n);
        if (simd == 1)
          for (int i = 0; i < LANES; i++) s += ((w >> (SWB * i)) & ((1 << SWB) - 1)) * m_b[i];
        else
          s += w * m_b[0];
        m_out_s = fitp(s);
      end
      m_out_e = w; m_inst_e = inst;
    end else if (ld == 1) begin
      if (os == 1) begin
        m_out_s = m_acc; m_acc = sx16(n);
        m_out_e = w; m_inst_e = inst;
      end else if (m_full == 1) begin
        m_out_e = w; m_inst_e = inst;
      end else begin
        if (m_cnt > 0 && simd != m_simd) m_cnt = 0;
        if (m_cnt == 0) m_simd = simd;
        if (simd == 0) begin
          for (int i = 0; i < LANES; i++) m_b[i] = sx4(w);
          m_full = 1; m_cnt = 0;
        end else begin
          m_b[m_cnt] = sx4(w);
          m_cnt++;
          if (m_cnt == LANES) begin m_full = 1; m_cnt = 0; end
        end
        m_inst_e = 0;
      end
    end else begin
      m_out_e = w; m_inst_e = inst;
    end
  endtask

  task automatic step(input logic [3:0] inst, input logic [3:0] w, input logic [15:0] n);
    inst_w = inst; in_w = w; in_n = n;
    model_step(int'(inst), int'(w), int'(n));
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    inst_w = 4'($urandom); in_w = 4'($urandom); in_n = 16'($urandom);
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_e !== 4'h0)  begin errors++; $display("FAIL rst_out_e got=%h exp=0", out_e); end
    checks++; if (inst_e !== 4'h0) begin errors++; $display("FAIL rst_inst_e got=%h exp=0", inst_e); end
    checks++; if (out_s !== 16'h0) begin errors++; $display("FAIL rst_out_s got=%h exp=0", out_s); end
    checks++; if (wt_full !== 1'b0) begin errors++; $display("FAIL rst_wt_full got=%b exp=0", wt_full); end
  endtask

  task automatic test_exec_priority();
    do_reset();
    step(4'b0011, 4'd5, 16'd9);
    checks++; if (out_s !== 16'd9)  begin errors++; $display("FAIL prio_out_s got=%h exp=9", out_s); end
    checks++; if (inst_e !== 4'b0011) begin errors++; $display("FAIL prio_inst_e got=%b exp=0011", inst_e); end
    checks++; if (wt_full !== 1'b0) begin errors++; $display("FAIL prio_wt_full got=%b exp=0", wt_full); end
  endtask

  task automatic test_ws_nonsimd();
    do_reset();
    step(4'b0001, 4'd3, 16'd0);
    checks++; if (inst_e !== 4'b0000) begin errors++; $display("FAIL ws_fill_inst_e got=%b exp=0000", inst_e); end
    checks++; if (wt_full !== 1'b1)   begin errors++; $display("FAIL ws_fill_full got=%b exp=1", wt_full); end
    checks++; if (out_e !== 4'd0)     begin errors++; $display("FAIL ws_fill_out_e got=%h exp=0", out_e); end
    step(4'b0001, 4'd5, 16'd0);
    checks++; if (inst_e !== 4'b0001) begin errors++; $display("FAIL ws_pass_inst_e got=%b exp=0001", inst_e); end
    checks++; if (out_e !== 4'd5)     begin errors++; $display("FAIL ws_pass_out_e got=%h exp=5", out_e); end
    step(4'b0010, 4'd2, 16'd10);
    checks++; if (out_s !== 16'd16)   begin errors++; $display("FAIL ws_exec_out_s got=%h exp=0010", out_s); end
  endtask

  task automatic test_ws_simd();
    do_reset();
    step(4'b1001, 4'd3, 16'd0);
    checks++; if (wt_full !== 1'b0) begin errors++; $display("FAIL simd_half_full got=%b exp=0", wt_full); end
    step(4'b1001, 4'hF, 16'd0);
    checks++; if (wt_full !== 1'b1) begin errors++; $display("FAIL simd_full got=%b exp=1", wt_full); end
    step(4'b1010, 4'b0110, 16'd0);
    checks++; if (out_s !== 16'd5)  begin errors++; $display("FAIL simd_exec_out_s got=%h exp=0005", out_s); end
  endtask

  task automatic test_simd_restart();
    do_reset();
    step(4'b1001, 4'd2, 16'd0);
    step(4'b0001, 4'd7, 16'd0);
    checks++; if (wt_full !== 1'b1) begin errors++; $display("FAIL restart_full got=%b exp=1", wt_full); end
    step(4'b0010, 4'd1, 16'd0);
    checks++; if (out_s !== 16'd7)  begin errors++; $display("FAIL restart_exec got=%h exp=0007", out_s); end
    step(4'b1010, 4'b0101, 16'd0);
    checks++; if (out_s !== 16'd14) begin errors++; $display("FAIL restart_simd_exec got=%h exp=000e", out_s); end
  endtask

  task automatic os_accumulate();
    step(4'b0110, 4'd4, 16'h0002);
    checks++; if (out_s !== 16'd2)  begin errors++; $display("FAIL os_fwd0 got=%h exp=0002", out_s); end
    step(4'b1110, 4'd1, 16'h0004);
    checks++; if (out_s !== 16'd4)  begin errors++; $display("FAIL os_fwd1 got=%h exp=0004", out_s); end
    step(4'b0110, 4'd1, 16'h000E);
    checks++; if (out_s !== 16'd14) begin errors++; $display("FAIL os_fwd2 got=%h exp=000e", out_s); end
  endtask

  task automatic test_os();
    do_reset();
    os_accumulate();
    step(4'b0101, 4'd0, 16'd7);
    checks++; if (out_s !== 16'd10)    begin errors++; $display("FAIL os_flush0 got=%h exp=000a", out_s); end
    checks++; if (inst_e !== 4'b0101)  begin errors++; $display("FAIL os_flush_inst_e got=%b exp=0101", inst_e); end
    step(4'b0101, 4'd0, 16'd0);
    checks++; if (out_s !== 16'd7)     begin errors++; $display("FAIL os_flush1 got=%h exp=0007", out_s); end
  endtask

  task automatic test_overflow();
    logic [15:0] exp_v;
`ifdef MAC_TILE_SATURATE_EN
    exp_v = 16'h7FFF;
`else
    exp_v = 16'h8014;
`endif
    do_reset();
    step(4'b0001, 4'd7, 16'd0);
    step(4'b0010, 4'd3, 16'd32767);
    checks++; if (out_s !== exp_v) begin errors++; $display("FAIL ovf_out_s got=%h exp=%h", out_s, exp_v); end
  endtask

  task automatic test_reset_midop();
    do_reset();
    os_accumulate();
    do_reset();
    checks++; if (out_s !== 16'h0)  begin errors++; $display("FAIL mid_rst_out_s got=%h exp=0", out_s); end
    checks++; if (inst_e !== 4'h0)  begin errors++; $display("FAIL mid_rst_inst_e got=%h exp=0", inst_e); end
    checks++; if (wt_full !== 1'b0) begin errors++; $display("FAIL mid_rst_wt_full got=%b exp=0", wt_full); end
    step(4'b0101, 4'd0, 16'd0);
    checks++; if (out_s !== 16'h0)  begin errors++; $display("FAIL mid_rst_flush got=%h exp=0 (acc)", out_s); end
  endtask

  task automatic test_random(input bit os_seg, input int ncyc);
    logic [3:0] inst;
    int r;
    do_reset();
    for (int c = 0; c < ncyc; c++) begin
      if (!os_seg && c % 20 == 19) do_reset();
      r = $urandom_range(0, 9);
      if (!os_seg) begin
        if (r < 3)      inst = {1'($urandom), 3'b001};
        else if (r < 8) inst = {1'($urandom), 3'b010};
        else if (r < 9) inst = 4'b0000;
        else            inst = {1'($urandom), 3'b011};
      end else begin
        if (r < 5)      inst = {1'($urandom), 3'b110};
        else if (r < 8) inst = 4'b0101;
        else if (r < 9) inst = 4'b0100;
        else            inst = 4'b0111;
      end
      step(inst, 4'($urandom), 16'($urandom));
      checks++; if (out_s !== 16'(m_out_s)) begin errors++; $display("FAIL rnd_out_s os=%0d cyc=%0d got=%h exp=%h", os_seg, c, out_s, 16'(m_out_s)); end
      checks++; if (out_e !== 4'(m_out_e)) begin errors++; $display("FAIL rnd_out_e os=%0d cyc=%0d got=%h exp=%h", os_seg, c, out_e, 4'(m_out_e)); end
      checks++; if (inst_e !== 4'(m_inst_e)) begin errors++; $display("FAIL rnd_inst_e os=%0d cyc=%0d got=%b exp=%b", os_seg, c, inst_e, 4'(m_inst_e)); end
      checks++; if (wt_full !== 1'(m_full)) begin errors++; $display("FAIL rnd_wt_full os=%0d cyc=%0d got=%b exp=%0d", os_seg, c, wt_full, m_full); end
    end
  endtask

  initial begin
    model_reset();
    @(posedge clk); #1;
    test_reset();
    test_exec_priority();
    test_ws_nonsimd();
    test_ws_simd();
    test_simd_restart();
    test_os();
    test_overflow();
    test_reset_midop();
    test_random(1'b0, 200);
    test_random(1'b1, 200);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule
